// File: rtl/mic_mem_responder.sv
// Multi-requester memory read responder: fixed-latency read pipeline with response ids,
// error flags and a saturating read counter. Optional word parity via MIC_MEM_PARITY_EN.
module mic_mem_responder #(
  parameter int unsigned NREQS   = 4,
  parameter int unsigned MDEPTH  = 256,
  parameter int unsigned AWIDTH  = 8,
  parameter int unsigned MWIDTH  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQS-1:0]         read_valid,
  input  logic [AWIDTH-1:0]        mem_addr,
  input  logic                     wr_en,
  input  logic [AWIDTH-1:0]        wr_addr,
  input  logic [MWIDTH-1:0]        wr_data,
`ifdef MIC_MEM_PARITY_EN
  input  logic                     par_inject,
`endif
  output logic [MWIDTH-1:0]        mem_rdata,
  output logic                     rdata_valid,
  output logic [$clog2(NREQS)-1:0] rsp_id,
  output logic                     rsp_err,
  output logic [15:0]              rd_count
);

  localparam int unsigned IdW = $clog2(NREQS);

  logic [MWIDTH-1:0] mem [MDEPTH];

  logic              accept;
  logic              multi_hot;
  logic              addr_oob;
  logic              wr_ok;
  logic              parity_bad;
  logic              err0;
  logic [IdW-1:0]    low_id;
  logic [AWIDTH-1:0] rd_idx;
  logic [MWIDTH-1:0] rd_word;
  logic [MWIDTH-1:0] data0;

  logic              valid_q [LATENCY];
  logic [IdW-1:0]    id_q    [LATENCY];
  logic [MWIDTH-1:0] data_q  [LATENCY];
  logic              err_q   [LATENCY];

  assign accept    = ~reset & (|read_valid);
  // x & (x-1) clears the lowest set bit; anything left means more than one requester.
  assign multi_hot = |(read_valid & (read_valid - NREQS'(1)));
  assign addr_oob  = 32'(mem_addr) >= MDEPTH;
  assign wr_ok     = wr_en & (32'(wr_addr) < MDEPTH);
  assign rd_idx    = addr_oob ? '0 : mem_addr;
  assign rd_word   = mem[rd_idx];

  always_comb begin
    low_id = '0;
    for (int i = int'(NREQS) - 1; i >= 0; i--) begin
      if (read_valid[i]) low_id = IdW'(i);
    end
  end

`ifdef MIC_MEM_PARITY_EN
  logic par_mem [MDEPTH];

  assign parity_bad = par_mem[rd_idx] != (^rd_word);

  always_ff @(posedge clock) begin
    if (wr_ok) par_mem[wr_addr] <= (^wr_data) ^ par_inject;
  end
`else
  assign parity_bad = 1'b0;
`endif

  assign err0  = multi_hot | addr_oob | parity_bad;
  // Parity errors still return the word; request-format errors return zero.
  assign data0 = (multi_hot | addr_oob) ? '0 : rd_word;

  // Memory is never reset; the read above sees pre-edge contents (read-first).
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        id_q[i]    <= '0;
        data_q[i]  <= '0;
        err_q[i]   <= 1'b0;
      end
    end else begin
      valid_q[0] <= accept;
      id_q[0]    <= accept ? low_id : '0;
      data_q[0]  <= accept ? data0 : '0;
      err_q[0]   <= accept & err0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
        data_q[i]  <= data_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count <= '0;
    end else if (accept && rd_count != 16'hFFFF) begin
      rd_count <= rd_count + 16'd1;
    end
  end

  assign rdata_valid = valid_q[LATENCY-1];
  assign mem_rdata   = rdata_valid ? data_q[LATENCY-1] : '0;
  assign rsp_id      = rdata_valid ? id_q[LATENCY-1] : '0;
  assign rsp_err     = rdata_valid & err_q[LATENCY-1];

endmodule

// File: tb/tb_mic_mem_responder.sv
// Directed bench for mic_mem_responder (NREQS=4, MDEPTH=200, LATENCY=2).
module tb_mic_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  read_valid;
  logic [7:0]  mem_addr;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] mem_rdata;
  logic        rdata_valid;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic [15:0] rd_count;
`ifdef MIC_MEM_PARITY_EN
  logic        par_inject;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mic_mem_responder #(
    .NREQS(4), .MDEPTH(200), .AWIDTH(8), .MWIDTH(32), .LATENCY(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .read_valid (read_valid),
    .mem_addr   (mem_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`ifdef MIC_MEM_PARITY_EN
    .par_inject (par_inject),
`endif
    .mem_rdata  (mem_rdata),
    .rdata_valid(rdata_valid),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .rd_count   (rd_count)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle();
    read_valid = '0;
    mem_addr   = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
`ifdef MIC_MEM_PARITY_EN
    par_inject = 1'b0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    // Preload addr i = i+100 while held in reset; also present a read that must be ignored.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = 32'(i + 100);
      read_valid = 4'b0001; mem_addr = 8'(i);
      tick();
    end
    idle();
    tick();
    n_checks++; if (rdata_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rdata_valid);
    else n_pass++;
    n_checks++; if (mem_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", mem_rdata);
    else n_pass++;
    n_checks++; if (rsp_id !== 2'd0) $display("FAIL rst_id: got %0d want 0", rsp_id);
    else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", rsp_err);
    else n_pass++;
    n_checks++; if (rd_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", rd_count);
    else n_pass++;
    reset = 1'b0;
    tick();
    tick();
    n_checks++; if (rdata_valid !== 1'b0) $display("FAIL rst_ignored: got %b want 0", rdata_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle();
    read_valid = 4'b0100; mem_addr = 8'd5;
    tick();
    idle();
    n_checks++; if (rdata_valid !== 1'b0) $display("FAIL basic_early: got %b want 0", rdata_valid);
    else n_pass++;
    tick();
    n_checks++; if (rdata_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", rdata_valid);
    else n_pass++;
    n_checks++; if (mem_rdata !== 32'hDEADBEEF)
      $display("FAIL basic_rdata: got %h want deadbeef", mem_rdata);
    else n_pass++;
    n_checks++; if (rsp_id !== 2'd2) $display("FAIL basic_id: got %0d want 2", rsp_id);
    else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL basic_err: got %b want 0", rsp_err);
    else n_pass++;
    tick();
    n_checks++; if (rdata_valid !== 1'b0) $display("FAIL basic_late: got %b want 0", rdata_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    idle();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i >= 2 && i < 6) begin
        n_checks++; if (rdata_valid !== 1'b1 || mem_rdata !== 32'(i + 98) || rsp_id !== 2'(i - 2))
          $display("FAIL b2b_rsp%0d: got v=%b d=%0d id=%0d want v=1 d=%0d id=%0d",
                   i - 2, rdata_valid, mem_rdata, rsp_id, i + 98, i - 2);
        else n_pass++;
      end else begin
        n_checks++; if (rdata_valid !== 1'b0)
          $display("FAIL b2b_idle%0d: got %b want 0", i, rdata_valid);
        else n_pass++;
      end
      if (i < 4) begin
        read_valid = 4'(1 << i); mem_addr = 8'(i);
      end else begin
        idle();
      end
      tick();
    end
    n_checks++; if (rd_count !== 16'd4) $display("FAIL b2b_count: got %0d want 4", rd_count);
    else n_pass++;
  endtask

  task automatic test_read_first();
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'h0;
    tick();
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'h1;
    read_valid = 4'b0001; mem_addr = 8'd7;
    tick();
    idle();
    read_valid = 4'b0010; mem_addr = 8'd7;
    tick();
    idle();
    n_checks++; if (rdata_valid !== 1'b1 || mem_rdata !== 32'h0 || rsp_id !== 2'd0)
      $display("FAIL rf_old: got v=%b d=%h id=%0d want v=1 d=0 id=0", rdata_valid, mem_rdata, rsp_id);
    else n_pass++;
    tick();
    n_checks++; if (rdata_valid !== 1'b1 || mem_rdata !== 32'h1 || rsp_id !== 2'd1)
      $display("FAIL rf_new: got v=%b d=%h id=%0d want v=1 d=1 id=1", rdata_valid, mem_rdata, rsp_id);
    else n_pass++;
  endtask

  task automatic test_errors();
    read_valid = 4'b0110; mem_addr = 8'd3;
    tick();
    read_valid = 4'b1000; mem_addr = 8'd250;
    tick();
    idle();
    n_checks++; if (rdata_valid !== 1'b1 || rsp_err !== 1'b1 || mem_rdata !== 32'h0 || rsp_id !== 2'd1)
      $display("FAIL err_multi: got v=%b e=%b d=%h id=%0d want v=1 e=1 d=0 id=1",
               rdata_valid, rsp_err, mem_rdata, rsp_id);
    else n_pass++;
    tick();
    n_checks++; if (rdata_valid !== 1'b1 || rsp_err !== 1'b1 || mem_rdata !== 32'h0 || rsp_id !== 2'd3)
      $display("FAIL err_oob: got v=%b e=%b d=%h id=%0d want v=1 e=1 d=0 id=3",
               rdata_valid, rsp_err, mem_rdata, rsp_id);
    else n_pass++;
    tick();
    n_checks++; if (rdata_valid !== 1'b0 || rsp_err !== 1'b0 || mem_rdata !== 32'h0 || rsp_id !== 2'd0)
      $display("FAIL err_quiet: got v=%b e=%b d=%h id=%0d want all 0",
               rdata_valid, rsp_err, mem_rdata, rsp_id);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    idle();
    do_reset();
    read_valid = 4'b0001; mem_addr = 8'd1;
    tick();
    read_valid = 4'b0010; mem_addr = 8'd2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rdata_valid !== 1'b0)
        $display("FAIL inflight_c%0d: got %b want 0", i + 2, rdata_valid);
      else n_pass++;
      tick();
    end
    n_checks++; if (rd_count !== 16'd0) $display("FAIL inflight_count: got %0d want 0", rd_count);
    else n_pass++;
  endtask

  task automatic test_saturation();
    idle();
    do_reset();
    read_valid = 4'b0001; mem_addr = 8'd0;
    repeat (65534) tick();
    n_checks++; if (rd_count !== 16'hFFFE) $display("FAIL sat_pre: got %h want fffe", rd_count);
    else n_pass++;
    tick();
    n_checks++; if (rd_count !== 16'hFFFF) $display("FAIL sat_max: got %h want ffff", rd_count);
    else n_pass++;
    repeat (3) tick();
    n_checks++; if (rd_count !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", rd_count);
    else n_pass++;
    idle();
    tick();
    tick();
  endtask

`ifdef MIC_MEM_PARITY_EN
  task automatic test_parity();
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'hA5A50F0F; par_inject = 1'b1;
    tick();
    idle();
    read_valid = 4'b0001; mem_addr = 8'd9;
    tick();
    read_valid = 4'b0001; mem_addr = 8'd5;
    tick();
    idle();
    n_checks++; if (rdata_valid !== 1'b1 || rsp_err !== 1'b1 || mem_rdata !== 32'hA5A50F0F)
      $display("FAIL par_bad: got v=%b e=%b d=%h want v=1 e=1 d=a5a50f0f",
               rdata_valid, rsp_err, mem_rdata);
    else n_pass++;
    tick();
    n_checks++; if (rdata_valid !== 1'b1 || rsp_err !== 1'b0 || mem_rdata !== 32'hDEADBEEF)
      $display("FAIL par_good: got v=%b e=%b d=%h want v=1 e=0 d=deadbeef",
               rdata_valid, rsp_err, mem_rdata);
    else n_pass++;
  endtask
`endif

  initial begin
    idle();
    reset = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_back_to_back();
    test_read_first();
    test_errors();
    test_reset_inflight();
`ifdef MIC_MEM_PARITY_EN
    test_parity();
`endif
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mic_mem_responder.md
MIC_MEM_RESPONDER -- requirements
Module: mic_mem_responder

Interface
REQ-001 Parameter NREQS, default 4: number of requesters; width of the read_valid one-hot.
REQ-002 Parameter MDEPTH, default 256: number of memory words.
REQ-003 Parameter AWIDTH, default 8: address width; SHALL satisfy 2**AWIDTH >= MDEPTH.
REQ-004 Parameter MWIDTH, default 32: data word width.
REQ-005 Parameter LATENCY, default 2: read latency in cycles; legal range 1..4.
REQ-006 Port clock, input, 1: sole clock; all logic on its rising edge.
REQ-007 Port reset, input, 1: reset, synchronous, active-high.
REQ-008 Port read_valid, input, NREQS: one-hot read request; the bit index identifies the requester.
REQ-009 Port mem_addr, input, AWIDTH: read address, qualified by any read_valid bit.
REQ-010 Port wr_en, input, 1: preload or backdoor write strobe.
REQ-011 Port wr_addr, input, AWIDTH: write address.
REQ-012 Port wr_data, input, MWIDTH: write data.
REQ-013 Port mem_rdata, output, MWIDTH: read data returned to the controller.
REQ-014 Port rdata_valid, output, 1: mem_rdata is valid this cycle.
REQ-015 Port rsp_id, output, $clog2(NREQS): index of the requester that owns the response.
REQ-016 Port rsp_err, output, 1: error flag, coincident with rdata_valid.
REQ-017 Port rd_count, output, 16: count of accepted reads, saturating.

Function
REQ-018 A read SHALL be accepted in every cycle in which read_valid != 0; there is no backpressure and the block accepts one read per cycle at full throughput.
REQ-019 An accepted read SHALL produce exactly one response cycle, with rdata_valid=1, exactly LATENCY cycles later, through a LATENCY-deep pipeline of valid/id/data/err.
REQ-020 rdata_valid SHALL be 0 in every cycle that has no accepted read LATENCY cycles earlier.
REQ-021 When rdata_valid=0, mem_rdata SHALL be 0, rsp_id SHALL be 0 and rsp_err SHALL be 0.
REQ-022 The memory array SHALL be MDEPTH x MWIDTH; when wr_en=1 and wr_addr < MDEPTH, wr_data is written at the clock edge.
REQ-023 A write with wr_addr >= MDEPTH SHALL be ignored.
REQ-024 A read and a write to the same address in the same cycle SHALL return the old data (read-first).
REQ-025 A read with mem_addr >= MDEPTH SHALL return mem_rdata=0 with rsp_err=1.
REQ-026 A read whose read_valid has more than one bit set SHALL be accepted as one read, with rsp_id equal to the lowest set bit index, and SHALL return rsp_err=1 with mem_rdata=0.
REQ-027 rsp_id SHALL equal the one-hot index of read_valid at acceptance, and rsp_id, mem_rdata and rsp_err SHALL stay aligned through the pipeline.
REQ-028 rd_count SHALL increment by 1 per accepted read, including erroneous reads.
REQ-029 rd_count SHALL saturate at 16'hFFFF and not wrap.

Reset
REQ-030 While reset=1, the pipeline SHALL be flushed, rdata_valid=0, mem_rdata=0, rsp_id=0, rsp_err=0 and rd_count=0, all at the next clock edge.
REQ-031 Reads in flight when reset asserts SHALL be discarded, and no response SHALL ever appear for them.
REQ-032 Reads presented while reset=1 SHALL be ignored and not counted.
REQ-033 Memory contents SHALL NOT be reset, and writes during reset SHALL still take effect.

Configuration
REQ-034 Macro MIC_MEM_PARITY_EN, when defined, SHALL store one even-parity bit per word on write.
REQ-035 With MIC_MEM_PARITY_EN defined, every read SHALL check the stored parity bit, and a mismatch SHALL set rsp_err=1 with mem_rdata still returned.
REQ-036 With MIC_MEM_PARITY_EN defined, an input port par_inject (1 bit, active-high) SHALL invert the stored parity bit on a write, for test.
REQ-037 With MIC_MEM_PARITY_EN undefined, there SHALL be no parity storage and no par_inject port, and rsp_err SHALL arise only under REQ-025 and REQ-026.

Verification
REQ-038 LATENCY=2: write 32'hDEADBEEF to addr 5, then read addr 5 with read_valid=4'b0100 -> two cycles later rdata_valid=1, mem_rdata=32'hDEADBEEF, rsp_id=2, rsp_err=0.
REQ-039 Back-to-back reads of addrs 0,1,2,3 on consecutive cycles (memory preloaded with data = addr+100) -> four consecutive response cycles returning 100,101,102,103 in order; rd_count=4.
REQ-040 Same-cycle write 32'h1 and read at addr 7, where addr 7 holds 32'h0 -> response 32'h0; a following read of addr 7 -> 32'h1.
REQ-041 read_valid=4'b0110 at addr 3 -> response has rsp_err=1, mem_rdata=0, rsp_id=1; with MDEPTH=200, read addr 250 -> rsp_err=1, mem_rdata=0.
REQ-042 Reads issued at cycles 0 and 1, reset asserted at cycle 1 for one cycle -> no rdata_valid at cycles 2 and 3; rd_count=0 after reset.
REQ-043 MIC_MEM_PARITY_EN defined: write addr 9 with par_inject=1, then read addr 9 -> rsp_err=1 with mem_rdata equal to the written data.
